// File: rtl/cbrt_pkg.sv
// Shared types and helpers for the iterative cube-root unit.
package cbrt_pkg;

    localparam int STEP_BITS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    function automatic int cbrt_rw(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/cbrt_step.sv
// One restoring cube-root iteration: tries root bit 1 against the current 3-bit group.
// Latency: combinational. Backpressure: none.
module cbrt_step #(
    parameter int PW = 9,
    parameter int RW = 3,
    parameter int SW = 4
) (
    input  logic [PW-1:0] x,
    input  logic [RW-1:0] y,
    input  logic [SW-1:0] s,
    output logic [PW-1:0] x_next,
    output logic [RW-1:0] y_next
);
    // Three spare bits keep the trial subtrahend and the compare free of overflow.
    localparam int BW = PW + 3;

    logic [BW-1:0] y2;
    logic [BW-1:0] t;
    logic [BW-1:0] b;
    logic          ge;

    always_comb begin
        y2     = BW'(y) << 1;
        t      = BW'(3) * y2 * (y2 + BW'(1)) + BW'(1);
        b      = t << s;
        ge     = {3'b000, x} >= b;
        x_next = ge ? (x - b[PW-1:0]) : x;
        y_next = RW'({y, ge});
    end

endmodule

// File: rtl/cbrt_iter.sv
// Iterative unsigned floor cube root, one 3-bit operand group per clock (CBRT_REM_EN builds rem).
// Latency: busy for RW cycles after the accepting edge, then a one-cycle valid pulse.
// Backpressure: start is ignored while busy; no queueing.
module cbrt_iter
    import cbrt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            a,
    output logic                        busy,
    output logic                        valid,
    output logic [cbrt_rw(WIDTH)-1:0]   root,
    output logic [WIDTH-1:0]            rem
);
    localparam int RW = cbrt_rw(WIDTH);
    localparam int PW = STEP_BITS * RW;
    localparam int SW = $clog2(PW + 1);

    state_t        state, state_nxt;
    logic [PW-1:0] x, x_nxt;
    logic [RW-1:0] y, y_nxt;
    logic [SW-1:0] s;
    logic          load, step_en, done;

    cbrt_step #(.PW(PW), .RW(RW), .SW(SW)) u_step (
        .x      (x),
        .y      (y),
        .s      (s),
        .x_next (x_nxt),
        .y_next (y_nxt)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_en   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (s == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            s     <= '0;
            root  <= '0;
        end else begin
            state <= state_nxt;
            valid <= done;
            if (load) begin
                x <= PW'(a);
                y <= '0;
                s <= SW'(STEP_BITS * (RW - 1));
            end else if (step_en) begin
                x <= x_nxt;
                y <= y_nxt;
                s <= s - SW'(STEP_BITS);
            end
            if (done) begin
                root <= y_nxt;
            end
        end
    end

`ifdef CBRT_REM_EN
    // Final x is always below 3y^2+3y+1, so it fits the operand width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
        end else if (done) begin
            rem <= WIDTH'(x_nxt);
        end
    end
`else
    assign rem = '0;
`endif

endmodule
